// File: rtl/pipelined_segment_adder.sv
// Pipelined two's-complement adder/subtractor. The carry chain is split into
// SEG_W-bit segments, one segment resolved per pipeline stage, so the clock
// rate depends on SEG_W rather than WIDTH. Valid/ready handshake on both sides
// with a single global stall.
`timescale 1ns/1ps
module pipelined_segment_adder #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG_W;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  // Per-stage registers. Every stage carries the full operands: upper segments
  // not yet consumed and lower sum segments already finished ride along with
  // the beat, and the final stage keeps the operand MSBs for the overflow flag.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  // Stage inputs (previous stage register, or the prepared operands for stage 0)
  // and the values each stage will capture.
  logic [WIDTH-1:0] a_i [STAGES];
  logic [WIDTH-1:0] b_i [STAGES];
  logic [WIDTH-1:0] s_i [STAGES];
  logic             c_i [STAGES];
  logic             v_i [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];

  logic [SEG_W:0]   seg;
  logic             adv;

  // Global advance: the whole pipe moves unless a finished result is blocked.
  assign out_valid = v_q[LAST];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Operand preparation and one segment add per stage.
  // NOTE: always_comb uses blocking '=' with every target given a value before
  // any branch or read, so no latch is inferred and temporaries read the
  // freshly computed value; clocked state below uses non-blocking '<=' only.
  always_comb begin
    seg     = '0;
    a_i[0]  = a;
    b_i[0]  = sub ? ~b : b;
    s_i[0]  = '0;
    c_i[0]  = sub ? 1'b1 : cin;
    v_i[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      s_i[k] = s_q[k-1];
      c_i[k] = c_q[k-1];
      v_i[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg    = {1'b0, a_i[k][k*SEG_W +: SEG_W]}
             + {1'b0, b_i[k][k*SEG_W +: SEG_W]}
             + {{SEG_W{1'b0}}, c_i[k]};
      s_d[k] = s_i[k];
      s_d[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
      c_d[k] = seg[SEG_W];
    end
  end

  // Stage registers: cleared by reset, shift together on adv, hold otherwise.
  // NOTE: the data registers are reset along with the valid bits because the
  // result outputs must read zero after reset; this is a handful of flops per
  // stage, not a memory, so the reset is cheap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_i[k];
      end
    end
  end

  // Results come straight from the final stage registers, so they stay stable
  // for as long as the stage holds.
  assign sum  = s_q[LAST];
  assign cout = c_q[LAST];
  assign ovf  = (a_q[LAST][MSB] == b_q[LAST][MSB]) && (s_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Self-checking bench for pipelined_segment_adder (WIDTH=16, SEG_W=4):
// reset, single-beat latency/arithmetic vectors, streaming, backpressure and
// reset while beats are in flight.
`timescale 1ns/1ps
module tb_pipelined_segment_adder;

  localparam int WIDTH  = 16;
  localparam int SEG_W  = 4;
  localparam int STAGES = WIDTH / SEG_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              cin = 1'b0;
  logic              sub = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;

  int checks   = 0;
  int failures = 0;

  pipelined_segment_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];
  logic [17:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: {cout, ovf, sum} straight from the operation definition.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    logic [15:0] bb;
    logic [16:0] r;
    logic        o;
    bb = msub ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub ? 1'b1 : mcin)};
    o  = (ma[15] == bb[15]) && (r[15] != ma[15]);
    return {r[16], o, r[15:0]};
  endfunction

  // Stream beat generator: mode 0 is the a=i, b=0x1000*i pattern, mode 1 mixes ops.
  task automatic gen_beat(input int mode, input int i);
    if (mode == 0) begin
      a   = 16'(i);
      b   = 16'(16'h1000 * i);
      cin = i[0];
      sub = 1'b0;
    end else begin
      a   = 16'(16'h1111 * i + 16'h0F0F);
      b   = 16'(16'hF000 - i);
      cin = i[0];
      sub = i[1];
    end
  endtask

  // One isolated beat: checks acceptance, latency and the result fields.
  task automatic run_single(input vec_t v, input string tag);
    int lat;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(STAGES));
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(v.sum));
    check({tag, "_cout"}, 32'(cout), 32'(v.cout));
    check({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
    tick();
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  // Streams n beats; out_ready is low for cycles [stall_start, stall_start+stall_len).
  task automatic run_stream(input int n, input int mode, input int stall_start,
                            input int stall_len, input string tag);
    int sent, got, cyc, first, last, extra;
    logic hold;
    logic [15:0] p_sum;
    logic p_cout, p_ovf;
    logic [17:0] e;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1; hold = 1'b0;
    p_sum = '0; p_cout = 1'b0; p_ovf = 1'b0;
    exp_q.delete();
    while (got < n && cyc < 100) begin
      out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      if (sent < n) begin
        gen_beat(mode, sent);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold) begin
        check({tag, "_hold_sum"}, 32'(sum), 32'(p_sum));
        check({tag, "_hold_cout"}, 32'(cout), 32'(p_cout));
        check({tag, "_hold_ovf"}, 32'(ovf), 32'(p_ovf));
      end
      check({tag, "_in_ready"}, 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        check({tag, "_unexpected_beat"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({tag, "_sum"}, 32'(sum), 32'(e[15:0]));
          check({tag, "_cout"}, 32'(cout), 32'(e[17]));
          check({tag, "_ovf"}, 32'(ovf), 32'(e[16]));
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      hold   = out_valid && !out_ready;
      p_sum  = sum;
      p_cout = cout;
      p_ovf  = ovf;
      cyc++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_delivered"}, 32'(got), 32'(n));
    check({tag, "_accepted"}, 32'(sent), 32'(n));
    check({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
    if (stall_len == 0)
      check({tag, "_consecutive"}, 32'(last - first), 32'(n - 1));
    extra = 0;
    repeat (8) begin
      if (out_valid) extra++;
      tick();
    end
    check({tag, "_no_duplicates"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int seen;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0001, 1'b1, 1'b1, 16'h00FE, 1'b1, 1'b0};
    vecs[8] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};

    // Reset held 3 cycles with a beat offered: nothing may be captured.
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'h1234; b = 16'h0101; cin = 1'b1; sub = 1'b0;
    tick(); tick(); tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // First beat after release doubles as the post-reset latency check.
    for (int i = 0; i < 9; i++)
      run_single(vecs[i], $sformatf("vec%0d", i));

    run_stream(8, 0, 1000, 0, "stream");
    run_stream(6, 1, 4, 3, "backpressure");

    // Reset one cycle before the first of three results is due.
    for (int i = 0; i < 3; i++) begin
      gen_beat(1, i + 3);
      in_valid = 1'b1;
      check($sformatf("midreset_accept%0d", i), 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("midreset_pre_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_sum_cleared", 32'(sum), 32'd0);
    seen = 0;
    repeat (12) begin
      if (out_valid) seen++;
      tick();
    end
    check("midreset_no_results", 32'(seen), 32'd0);

    // Pipe still works after the mid-flight reset.
    run_single(vecs[1], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
